// File: rtl/rxfifo_rd_machine.sv
// Rx FIFO read-side engine: pulls one word per request from a standard FIFO read port
// and delivers it to either the descriptor fetch path (priority) or the Linux read path.
module rxfifo_rd_machine #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rxfifo_empty,
    output logic                  rxfifo_rd_en,
    input  logic [DATA_WIDTH-1:0] rxfifo_dread,
    input  logic                  rxfifo_valid,
    input  logic                  rxfifo_underflow,
    input  logic                  linux_rd_start,
    input  logic                  desc_rd_start,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_done,
    output logic                  rd_owner,
    output logic                  rd_err,
    output logic [CNT_WIDTH-1:0]  rd_word_count
);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_RD         = 2'd1;
    localparam logic [1:0] ST_WAIT_VALID = 2'd2;
    localparam logic [1:0] ST_DONE       = 2'd3;

    localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]            r_state;
    logic                  r_pend_linux;
    logic                  r_pend_desc;
    logic                  r_owner;
    logic [7:0]            r_tmo_cnt;
    logic                  r_rd_en;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_done;
    logic                  r_rd_owner;
    logic                  r_rd_err;
    logic [CNT_WIDTH-1:0]  r_word_count;

    logic [1:0]            w_state_nxt;
    logic                  w_pend_linux_nxt;
    logic                  w_pend_desc_nxt;
    logic                  w_owner_nxt;
    logic [7:0]            w_tmo_cnt_nxt;
    logic                  w_rd_en_nxt;
    logic [DATA_WIDTH-1:0] w_rd_data_nxt;
    logic                  w_rd_done_nxt;
    logic                  w_rd_owner_nxt;
    logic                  w_rd_err_nxt;
    logic [CNT_WIDTH-1:0]  w_word_count_nxt;

    logic w_req_linux;
    logic w_req_desc;
    logic w_grant;
    logic w_grant_linux;
    logic w_grant_desc;

    assign w_req_linux   = r_pend_linux | linux_rd_start;
    assign w_req_desc    = r_pend_desc | desc_rd_start;
    assign w_grant       = (r_state == ST_IDLE) && (w_req_linux || w_req_desc) && !rxfifo_empty;
    assign w_grant_desc  = w_grant & w_req_desc;
    assign w_grant_linux = w_grant & ~w_req_desc;

    // A start seen in any state re-arms its flag; only the grant cycle consumes it.
    assign w_pend_linux_nxt = w_grant_linux ? 1'b0 : w_req_linux;
    assign w_pend_desc_nxt  = w_grant_desc ? 1'b0 : w_req_desc;

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_tmo_cnt_nxt    = r_tmo_cnt;
        w_rd_en_nxt      = 1'b0;
        w_rd_data_nxt    = r_rd_data;
        w_rd_done_nxt    = 1'b0;
        w_rd_owner_nxt   = r_rd_owner;
        w_rd_err_nxt     = 1'b0;
        w_word_count_nxt = r_word_count;

        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_owner_nxt = w_req_desc;
                    w_rd_en_nxt = 1'b1;
                    w_state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                w_tmo_cnt_nxt = '0;
                w_state_nxt   = ST_WAIT_VALID;
            end
            ST_WAIT_VALID: begin
                if (rxfifo_valid) begin
                    w_rd_data_nxt    = rxfifo_dread;
                    w_rd_done_nxt    = 1'b1;
                    w_rd_owner_nxt   = r_owner;
                    w_word_count_nxt = r_word_count + CNT_WIDTH'(1);
                    w_state_nxt      = ST_DONE;
                end else if (rxfifo_underflow || (r_tmo_cnt == LP_TMO_LAST)) begin
                    // Failed request is consumed; rd_data keeps the last good word.
                    w_rd_done_nxt  = 1'b1;
                    w_rd_err_nxt   = 1'b1;
                    w_rd_owner_nxt = r_owner;
                    w_state_nxt    = ST_DONE;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 8'd1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_pend_linux <= 1'b0;
            r_pend_desc  <= 1'b0;
            r_owner      <= 1'b0;
            r_tmo_cnt    <= '0;
            r_rd_en      <= 1'b0;
            r_rd_data    <= '0;
            r_rd_done    <= 1'b0;
            r_rd_owner   <= 1'b0;
            r_rd_err     <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pend_linux <= w_pend_linux_nxt;
            r_pend_desc  <= w_pend_desc_nxt;
            r_owner      <= w_owner_nxt;
            r_tmo_cnt    <= w_tmo_cnt_nxt;
            r_rd_en      <= w_rd_en_nxt;
            r_rd_data    <= w_rd_data_nxt;
            r_rd_done    <= w_rd_done_nxt;
            r_rd_owner   <= w_rd_owner_nxt;
            r_rd_err     <= w_rd_err_nxt;
            r_word_count <= w_word_count_nxt;
        end
    end

    assign rxfifo_rd_en  = r_rd_en;
    assign rd_data       = r_rd_data;
    assign rd_done       = r_rd_done;
    assign rd_owner      = r_rd_owner;
    assign rd_err        = r_rd_err;
    assign rd_word_count = r_word_count;

endmodule

// File: tb/tb_rxfifo_rd_machine.sv
// Bench for rxfifo_rd_machine: FIFO model with read latency 1, vector table plus
// hand-written corner sequences, completions checked against an expectation queue.
module tb_rxfifo_rd_machine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        rxfifo_empty;
    logic        rxfifo_rd_en;
    logic [31:0] rxfifo_dread = '0;
    logic        rxfifo_valid = 1'b0;
    logic        rxfifo_underflow = 1'b0;
    logic        linux_rd_start = 1'b0;
    logic        desc_rd_start = 1'b0;
    logic [31:0] rd_data;
    logic        rd_done;
    logic        rd_owner;
    logic        rd_err;
    logic [15:0] rd_word_count;

    rxfifo_rd_machine #(
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16),
        .CNT_WIDTH     (16)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .rxfifo_empty    (rxfifo_empty),
        .rxfifo_rd_en    (rxfifo_rd_en),
        .rxfifo_dread    (rxfifo_dread),
        .rxfifo_valid    (rxfifo_valid),
        .rxfifo_underflow(rxfifo_underflow),
        .linux_rd_start  (linux_rd_start),
        .desc_rd_start   (desc_rd_start),
        .rd_data         (rd_data),
        .rd_done         (rd_done),
        .rd_owner        (rd_owner),
        .rd_err          (rd_err),
        .rd_word_count   (rd_word_count)
    );

    always #5 clk = ~clk;

    // FIFO model: words written by the stimulus, popped on rd_en, valid one cycle later.
    logic [31:0] fifo_mem [0:255];
    logic [7:0]  wr_cnt = '0;
    logic [7:0]  rd_cnt = '0;
    logic        hold_valid = 1'b0;

    assign rxfifo_empty = (wr_cnt == rd_cnt);

    always @(posedge clk) begin
        if (rxfifo_rd_en && (rd_cnt != wr_cnt)) begin
            rxfifo_dread <= fifo_mem[rd_cnt];
            rxfifo_valid <= !hold_valid;
            rd_cnt       <= rd_cnt + 8'd1;
        end else begin
            rxfifo_valid <= 1'b0;
        end
    end

    typedef struct packed {
        logic        owner;
        logic        err;
        logic [31:0] data;
        logic [15:0] count;
    } exp_t;

    typedef struct packed {
        logic        lin;
        logic        desc;
        logic [31:0] word;
        logic        owner;
    } vec_t;

    exp_t        sb_q[$];
    logic [31:0] m_last = '0;
    logic [15:0] m_count = '0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        prev_rd_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, wanted 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_mem[wr_cnt] = w;
        wr_cnt = wr_cnt + 8'd1;
    endtask

    task automatic expect_done(input logic owner, input logic err, input logic [31:0] data);
        exp_t e;
        if (!err) begin
            m_last  = data;
            m_count = m_count + 16'd1;
        end
        e.owner = owner;
        e.err   = err;
        e.data  = m_last;
        e.count = m_count;
        sb_q.push_back(e);
    endtask

    // Advance one clock and compare any completion against the expectation queue.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (rd_done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got rd_done=1, wanted no completion at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                check("done_owner", 32'(rd_owner), 32'(e.owner));
                check("done_err", 32'(rd_err), 32'(e.err));
                check("done_data", rd_data, e.data);
                check("done_count", 32'(rd_word_count), 32'(e.count));
            end
        end
        if (rxfifo_rd_en) check("rd_en_single_cycle", 32'(prev_rd_en), 32'd0);
        prev_rd_en = rxfifo_rd_en;
    endtask

    initial begin
        vec_t vecs [4];
        int   t_first;
        int   t_second;

        vecs[0] = '{lin: 1'b1, desc: 1'b0, word: 32'hDEADBEEF, owner: 1'b0};
        vecs[1] = '{lin: 1'b0, desc: 1'b1, word: 32'h12345678, owner: 1'b1};
        vecs[2] = '{lin: 1'b1, desc: 1'b0, word: 32'h00000000, owner: 1'b0};
        vecs[3] = '{lin: 1'b0, desc: 1'b1, word: 32'hFFFFFFFF, owner: 1'b1};

        // Reset: outputs must be cleared.
        #3 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_en", 32'(rxfifo_rd_en), 32'd0);
        check("rst_done", 32'(rd_done), 32'd0);
        check("rst_owner", 32'(rd_owner), 32'd0);
        check("rst_err", 32'(rd_err), 32'd0);
        check("rst_data", rd_data, 32'd0);
        check("rst_count", 32'(rd_word_count), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Single reads from the table: rd_en at cycle 1 only, rd_done at cycle 3.
        for (int i = 0; i < 4; i++) begin
            push_word(vecs[i].word);
            expect_done(vecs[i].owner, 1'b0, vecs[i].word);
            linux_rd_start = vecs[i].lin;
            desc_rd_start  = vecs[i].desc;
            tick();
            check("vec_rd_en_c1", 32'(rxfifo_rd_en), 32'd1);
            linux_rd_start = 1'b0;
            desc_rd_start  = 1'b0;
            tick();
            check("vec_rd_en_c2", 32'(rxfifo_rd_en), 32'd0);
            tick();
            check("vec_done_c3", 32'(rd_done), 32'd1);
            tick();
        end

        // Simultaneous starts: descriptor first, Linux 4 cycles later.
        push_word(32'h11);
        push_word(32'h22);
        expect_done(1'b1, 1'b0, 32'h11);
        expect_done(1'b0, 1'b0, 32'h22);
        linux_rd_start = 1'b1;
        desc_rd_start  = 1'b1;
        t_first  = -1;
        t_second = -1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            linux_rd_start = 1'b0;
            desc_rd_start  = 1'b0;
            if (rd_done && t_first < 0) t_first = c;
            else if (rd_done && t_second < 0) t_second = c;
        end
        check("simul_first_cycle", 32'(t_first), 32'd3);
        check("simul_second_cycle", 32'(t_second), 32'd7);

        // Empty FIFO blocks the grant; done 3 cycles after the word lands.
        desc_rd_start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            desc_rd_start = 1'b0;
            check("empty_no_rd_en", 32'(rxfifo_rd_en), 32'd0);
        end
        push_word(32'hA5);
        expect_done(1'b1, 1'b0, 32'hA5);
        t_first = -1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (rd_done && t_first < 0) t_first = c;
        end
        check("empty_done_cycle", 32'(t_first), 32'd3);

        // Timeout: valid withheld, error 16 cycles after entering WAIT_VALID (cycle 2).
        hold_valid = 1'b1;
        push_word(32'h77);
        expect_done(1'b0, 1'b1, 32'h0);
        linux_rd_start = 1'b1;
        t_first = -1;
        for (int c = 1; c <= 25; c++) begin
            tick();
            linux_rd_start = 1'b0;
            if (rd_done && t_first < 0) t_first = c;
        end
        check("timeout_done_cycle", 32'(t_first), 32'd18);
        hold_valid = 1'b0;

        // Start while the same source is served: served twice.
        push_word(32'h31);
        push_word(32'h32);
        expect_done(1'b0, 1'b0, 32'h31);
        expect_done(1'b0, 1'b0, 32'h32);
        linux_rd_start = 1'b1;
        t_first  = -1;
        t_second = -1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            linux_rd_start = (c == 2);
            if (rd_done && t_first < 0) t_first = c;
            else if (rd_done && t_second < 0) t_second = c;
        end
        check("restart_first_cycle", 32'(t_first), 32'd3);
        check("restart_second_cycle", 32'(t_second), 32'd7);

        // Underflow in WAIT_VALID gives an error completion.
        hold_valid = 1'b1;
        push_word(32'h40);
        expect_done(1'b0, 1'b1, 32'h0);
        linux_rd_start = 1'b1;
        tick();
        linux_rd_start = 1'b0;
        tick();
        rxfifo_underflow = 1'b1;
        tick();
        rxfifo_underflow = 1'b0;
        check("underflow_done", 32'(rd_done), 32'd1);
        tick();
        hold_valid = 1'b0;

        // The next request after the error proceeds normally.
        push_word(32'h41);
        expect_done(1'b1, 1'b0, 32'h41);
        desc_rd_start = 1'b1;
        tick();
        desc_rd_start = 1'b0;
        repeat (4) tick();

        // Reset in WAIT_VALID with a descriptor request pending.
        hold_valid = 1'b1;
        push_word(32'h50);
        push_word(32'h51);
        linux_rd_start = 1'b1;
        tick();
        linux_rd_start = 1'b0;
        tick();
        desc_rd_start = 1'b1;
        tick();
        desc_rd_start = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("midrst_rd_en", 32'(rxfifo_rd_en), 32'd0);
        check("midrst_done", 32'(rd_done), 32'd0);
        check("midrst_owner", 32'(rd_owner), 32'd0);
        check("midrst_err", 32'(rd_err), 32'd0);
        check("midrst_data", rd_data, 32'd0);
        check("midrst_count", 32'(rd_word_count), 32'd0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        hold_valid = 1'b0;
        m_last  = '0;
        m_count = '0;
        for (int c = 0; c < 12; c++) begin
            tick();
            check("post_rst_no_rd_en", 32'(rxfifo_rd_en), 32'd0);
        end
        check("post_rst_count", 32'(rd_word_count), 32'd0);

        // A fresh start after reset reads the word left in the FIFO.
        expect_done(1'b1, 1'b0, 32'h51);
        desc_rd_start = 1'b1;
        tick();
        desc_rd_start = 1'b0;
        repeat (5) tick();

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rxfifo_rd_machine.md
Name: rxfifo_rd_machine

Overview:
- Drains the Rx FIFO one word per request and hands each word to one of two consumers: the Linux register-read path or the descriptor fetch path.
- Sits between a standard (non-FWFT) FIFO read port and the AXI-side user logic. It is the read-side counterpart of the Rx FIFO write dispatcher.
- Start pulses from either consumer are latched, so a request is never lost while the engine is busy.
- The descriptor path has fixed priority over the Linux path.

Parameters:
- DATA_WIDTH, 32, FIFO word and user data width.
- TIMEOUT_CYCLES, 16, maximum cycles to wait for rxfifo_valid after a read strobe; legal range 1..255.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rxfifo_empty  in  1  FIFO empty flag.
- rxfifo_rd_en  out  1  FIFO read strobe, one cycle per word.
- rxfifo_dread  in  DATA_WIDTH  FIFO read data, qualified by rxfifo_valid.
- rxfifo_valid  in  1  FIFO read-data valid.
- rxfifo_underflow  in  1  FIFO underflow indication.
- linux_rd_start  in  1  Linux read request pulse.
- desc_rd_start  in  1  descriptor read request pulse.
- rd_data  out  DATA_WIDTH  delivered word; holds its value until the next capture.
- rd_done  out  1  one-cycle completion pulse.
- rd_owner  out  1  consumer of the current completion: 0 = Linux, 1 = descriptor; valid while rd_done=1.
- rd_err  out  1  error qualifier, valid with rd_done: 1 means timeout or underflow, and rd_data is unchanged.
- rd_word_count  out  CNT_WIDTH  number of successful deliveries; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset:
  - Asserting reset_n low immediately clears every output, pend_linux, pend_desc, the timeout counter and the state (IDLE).
  - A reset mid-transaction abandons the transaction. A word already strobed out of the FIFO is discarded, and no rd_done is issued.
- Pending flags:
  - pend_x is set on x_rd_start.
  - pend_x is cleared on the cycle the request is granted.
  - A start arriving while that same source is being served sets pend_x again, so the source is served a second time.
  - Repeated starts while a source is already pending merge into one request.
- FSM states: IDLE, RD, WAIT_VALID, DONE.
- IDLE:
  - The request term for each source is req_x = pend_x | x_rd_start.
  - If (req_desc | req_linux) and !rxfifo_empty: grant the source (desc wins over linux), record it as owner, clear its pend flag, set rxfifo_rd_en<=1 and go to RD.
  - If the FIFO is empty, remain in IDLE with the requests pending. There is no timeout while empty.
- RD:
  - rxfifo_rd_en<=0, so the strobe is high for exactly one cycle.
  - Clear the timeout counter and go to WAIT_VALID.
- WAIT_VALID, evaluated in priority order:
  - rxfifo_valid=1: rd_data<=rxfifo_dread, rd_done<=1, rd_err<=0, rd_owner<=owner, rd_word_count increments, go to DONE.
  - rxfifo_underflow=1: rd_done<=1, rd_err<=1, go to DONE.
  - Timeout counter reaches TIMEOUT_CYCLES-1: rd_done<=1, rd_err<=1, go to DONE.
  - Otherwise: increment the counter.
  - If valid and underflow arrive in the same cycle, valid wins.
- DONE: rd_done<=0, rd_err<=0, go to IDLE. A remaining pending request may be granted on the next IDLE cycle.
- Latency: with a FIFO read latency of 1, a start at cycle 0 (IDLE, non-empty FIFO) gives:
  - rxfifo_rd_en at cycle 1;
  - rxfifo_valid at cycle 2;
  - rd_done at cycle 3.
- Throughput: one word per 4 cycles.
- Errors:
  - rd_word_count does not increment on an error completion.
  - The failed request is consumed, not retried.
- rxfifo_rd_en is never asserted while rxfifo_empty=1 was seen at the grant cycle. At most one read is outstanding at any time.

Test Plan:
1. Single read: FIFO holds 0xDEADBEEF, linux_rd_start pulse at cycle 0 -> rxfifo_rd_en high cycle 1 only; rd_done at cycle 3 with rd_data=0xDEADBEEF, rd_owner=0, rd_err=0; rd_word_count=1.
2. Simultaneous starts: FIFO holds 0x11, 0x22, both starts in the same cycle -> first rd_done has owner=1 and data 0x11; second rd_done has owner=0 and data 0x22, arriving 4 cycles later; count=2.
3. Empty blocking: desc_rd_start with FIFO empty for 20 cycles, then 0xA5 is written -> no rxfifo_rd_en while empty; rd_done with data 0xA5 arrives 3 cycles after empty deasserts.
4. Timeout: rxfifo_valid held low after the strobe, TIMEOUT_CYCLES=16 -> rd_done=1 with rd_err=1, 16 cycles after entering WAIT_VALID; rd_data unchanged; count unchanged.
5. Start during service plus underflow: linux start while Linux is being served -> served twice. Then inject underflow in WAIT_VALID -> rd_err=1 completion, and the next request proceeds normally.
6. Reset mid-operation: assert reset_n in WAIT_VALID with a desc request pending -> all outputs 0 asynchronously; after release, no rd_done without a new start; count=0.
